enemy_wave_controller: RTL and testbench

Parametrised successor to the single-wave fly enemy block. It owns positions, liveness and bullet collision for `ENEMY_COUNT` descending enemies against `BULLET_COUNT` player bullets. Collisions are checked every cycle with one-to-one hit arbitration. When the last enemy dies, the block advances through timed waves with increasing descent speed. It sits between the bullet controller (bullet positions in, `bullet_hit` out) and the sprite renderer / score logic.

---
 rtl/enemy_wave_controller.sv | 194 +++++++++++++++++++
 tb/tb_enemy_wave_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_controller.sv
// enemy_wave_controller: ENEMY_COUNT descending enemies against BULLET_COUNT
// player bullets. Hits are checked every cycle with one-to-one arbitration.
// Clearing a wave starts a timed pause, then the next, faster wave spawns.
// Optional build macro: ENEMY_ESCAPE_KILL_EN. When it is defined, an enemy
// that reaches the bottom dies instead of wrapping back to the top.

// Overlap test of one enemy hitbox against every bullet slot.
module enemy_wave_hit_lane #(
  parameter int BULLET_COUNT = 8,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32
) (
  input  logic [9:0]                 ex,
  input  logic [9:0]                 ey,
  input  logic                       en,
  input  logic [10*BULLET_COUNT-1:0] bx_flat,
  input  logic [10*BULLET_COUNT-1:0] by_flat,
  input  logic [BULLET_COUNT-1:0]    bact,
  output logic [BULLET_COUNT-1:0]    ovl
);
  // The box edges are 11 bits wide so a box near 1023 cannot wrap around.
  logic [10:0] ex_end, ey_end;
  assign ex_end = {1'b0, ex} + 11'(SPRITE_W);
  assign ey_end = {1'b0, ey} + 11'(SPRITE_H);

  for (genvar j = 0; j < BULLET_COUNT; j++) begin : g_b
    logic [9:0] bx, by;
    assign bx = bx_flat[j*10 +: 10];
    assign by = by_flat[j*10 +: 10];
    assign ovl[j] = en && bact[j] && (bx >= ex) && ({1'b0, bx} < ex_end)
                    && (by >= ey) && ({1'b0, by} < ey_end);
  end
endmodule

module enemy_wave_controller #(
  parameter int ENEMY_COUNT  = 4,
  parameter int BULLET_COUNT = 8,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int SCREEN_H     = 480,
  parameter int X_BASE       = 200,
  parameter int X_STEP       = 50,
  parameter int MOVE_PERIOD  = 524288,
  parameter int STEP_BASE    = 2,
  parameter int STEP_MAX     = 8,
  parameter int CLEAR_TICKS  = 64
) (
  input  logic                       clk25,
  input  logic                       rst_n,
  input  logic [10*BULLET_COUNT-1:0] bullet_x_flat,
  input  logic [10*BULLET_COUNT-1:0] bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]    bullet_active_flat,
  output logic [10*ENEMY_COUNT-1:0]  fly_x_flat,
  output logic [10*ENEMY_COUNT-1:0]  fly_y_flat,
  output logic [ENEMY_COUNT-1:0]     fly_alive,
  output logic [ENEMY_COUNT-1:0]     fly_hit,
  output logic [BULLET_COUNT-1:0]    bullet_hit,
  output logic [ENEMY_COUNT-1:0]     enemy_escaped,
  output logic                       wave_clear,
  output logic [7:0]                 wave_num
);
  typedef enum logic {ACTIVE = 1'b0, CLEAR = 1'b1} state_t;

  localparam int TW = $clog2(MOVE_PERIOD);
  localparam int CW = $clog2(CLEAR_TICKS + 1);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H - SPRITE_H);

  state_t                                 state_q, state_d;
  logic [TW-1:0]                          tick_cnt;
  logic                                   tick;
  logic [CW-1:0]                          clear_cnt;
  logic                                   clear_done, is_active, respawn, last;
  logic [ENEMY_COUNT-1:0][9:0]            y_q;
  logic [ENEMY_COUNT-1:0]                 alive_q, kill, esc, dead_now;
  logic [BULLET_COUNT-1:0]                bhit;
  logic [ENEMY_COUNT-1:0][BULLET_COUNT-1:0] ovl;
  logic [BULLET_COUNT-1:0][ENEMY_COUNT-1:0] tgt;
  logic [9:0]                             step_raw, step;

  assign tick       = (tick_cnt == TW'(MOVE_PERIOD - 1));
  assign clear_done = (clear_cnt == CW'(CLEAR_TICKS - 1));
  assign step_raw   = 10'(STEP_BASE) + {2'b00, wave_num};
  assign step       = (step_raw > 10'(STEP_MAX)) ? 10'(STEP_MAX) : step_raw;
  assign fly_alive  = alive_q;

  // One overlap lane per enemy. Dead enemies and the CLEAR state mask the lane.
  for (genvar i = 0; i < ENEMY_COUNT; i++) begin : g_lane
    enemy_wave_hit_lane #(
      .BULLET_COUNT(BULLET_COUNT), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)
    ) u_lane (
      .ex(10'(X_BASE + i*X_STEP)), .ey(y_q[i]), .en(is_active && alive_q[i]),
      .bx_flat(bullet_x_flat), .by_flat(bullet_y_flat), .bact(bullet_active_flat),
      .ovl(ovl[i])
    );
    assign fly_x_flat[i*10 +: 10] = 10'(X_BASE + i*X_STEP);
    assign fly_y_flat[i*10 +: 10] = y_q[i];
  end

  // Free-running move tick divider.
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

  // Each bullet targets only the lowest-index enemy it overlaps.
  always_comb begin
    tgt = '0;
    for (int j = 0; j < BULLET_COUNT; j++)
      for (int i = ENEMY_COUNT - 1; i >= 0; i--)
        if (ovl[i][j]) begin
          tgt[j]    = '0;
          tgt[j][i] = 1'b1;
        end
  end

  // Each enemy goes to the lowest-index bullet that targets it. Losing bullets stay live.
  always_comb begin
    kill = '0;
    bhit = '0;
    for (int j = 0; j < BULLET_COUNT; j++)
      for (int i = 0; i < ENEMY_COUNT; i++)
        if (tgt[j][i] && !kill[i]) begin
          kill[i] = 1'b1;
          bhit[j] = 1'b1;
        end
  end

  // Bottom reached on a tick. An enemy killed in the same cycle does not escape.
  always_comb begin
    esc = '0;
    for (int i = 0; i < ENEMY_COUNT; i++)
      esc[i] = is_active && tick && alive_q[i] && !kill[i] && (y_q[i] >= Y_LIM);
  end

`ifdef ENEMY_ESCAPE_KILL_EN
  assign dead_now = kill | esc;
`else
  assign dead_now = kill;
`endif

  assign last = is_active && (alive_q != '0) && ((alive_q & ~dead_now) == '0);

  // FSM state register.
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) state_q <= ACTIVE;
    else        state_q <= state_d;

  // FSM next state: enter CLEAR on the last death, leave it after the pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (last) state_d = CLEAR;
      CLEAR:   if (tick && clear_done) state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    is_active = (state_q == ACTIVE);
    respawn   = (state_q == CLEAR) && tick && clear_done;
  end

  // Enemy positions, liveness, pulses, the pause counter and the wave index.
  always_ff @(posedge clk25 or negedge rst_n)
    if (!rst_n) begin
      y_q           <= '0;
      alive_q       <= '1;
      fly_hit       <= '0;
      bullet_hit    <= '0;
      enemy_escaped <= '0;
      wave_clear    <= 1'b0;
      wave_num      <= '0;
      clear_cnt     <= '0;
    end else begin
      fly_hit       <= kill;
      bullet_hit    <= bhit;
      enemy_escaped <= esc;
      wave_clear    <= last;
      if (respawn) begin
        y_q       <= '0;
        alive_q   <= '1;
        wave_num  <= wave_num + 8'd1;
        clear_cnt <= '0;
      end else begin
        if (!is_active && tick) clear_cnt <= clear_cnt + 1'b1;
        alive_q <= alive_q & ~dead_now;
        for (int i = 0; i < ENEMY_COUNT; i++)
          if (esc[i])
            y_q[i] <= '0;
          else if (is_active && tick && alive_q[i] && !kill[i])
            y_q[i] <= y_q[i] + step;
      end
    end
endmodule

// File: tb/tb_enemy_wave_controller.sv
// Self-checking bench for enemy_wave_controller. A behavioral reference model
// steps on every clock and pushes the expected output word to a scoreboard
// queue. The word is popped and compared just after the DUT edge. Directed
// checks pin the literal values of the documented scenarios.
`timescale 1ns/1ps
module tb_enemy_wave_controller;
  localparam int EC = 4, BC = 8, MP = 4, CT = 4;

  logic clk25, rst_n;
  logic [10*BC-1:0] bx_flat, by_flat;
  logic [BC-1:0]    bact;
  logic [10*EC-1:0] fly_x_flat, fly_y_flat;
  logic [EC-1:0]    fly_alive, fly_hit, enemy_escaped;
  logic [BC-1:0]    bullet_hit;
  logic             wave_clear;
  logic [7:0]       wave_num;

  enemy_wave_controller #(
    .ENEMY_COUNT(EC), .BULLET_COUNT(BC), .SPRITE_W(32), .SPRITE_H(32),
    .SCREEN_H(480), .X_BASE(200), .X_STEP(50), .MOVE_PERIOD(MP),
    .STEP_BASE(2), .STEP_MAX(8), .CLEAR_TICKS(CT)
  ) dut (
    .clk25(clk25), .rst_n(rst_n),
    .bullet_x_flat(bx_flat), .bullet_y_flat(by_flat), .bullet_active_flat(bact),
    .fly_x_flat(fly_x_flat), .fly_y_flat(fly_y_flat), .fly_alive(fly_alive),
    .fly_hit(fly_hit), .bullet_hit(bullet_hit), .enemy_escaped(enemy_escaped),
    .wave_clear(wave_clear), .wave_num(wave_num)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int         m_cnt, m_ccnt;
  bit         m_act;
  logic [7:0] m_wave;
  logic [9:0] m_y[EC];
  logic [EC-1:0] m_alive, m_hit, m_esc;
  logic [BC-1:0] m_bhit;
  logic          m_wc;
  logic [108:0]  sb[$];

  task automatic m_reset();
    m_cnt = 0; m_ccnt = 0; m_act = 1; m_wave = 0; m_alive = '1;
    for (int i = 0; i < EC; i++) m_y[i] = 0;
    m_hit = 0; m_esc = 0; m_bhit = 0; m_wc = 0;
  endtask

  function automatic bit inbox(int i, int j);
    int ex, ey, bx, by;
    ex = 200 + 50*i; ey = int'(m_y[i]);
    bx = int'(bx_flat[j*10 +: 10]); by = int'(by_flat[j*10 +: 10]);
    return (bx >= ex) && (bx < ex + 32) && (by >= ey) && (by < ey + 32);
  endfunction

  task automatic m_step();
    bit tick; int tgt[BC]; int step; logic [EC-1:0] dead;
    tick  = (m_cnt == MP - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_hit = 0; m_bhit = 0; m_esc = 0; m_wc = 0;
    step  = 2 + int'(m_wave);
    if (step > 8) step = 8;
    if (m_act) begin
      for (int j = 0; j < BC; j++) begin
        tgt[j] = -1;
        if (bact[j])
          for (int i = 0; i < EC; i++)
            if (tgt[j] < 0 && m_alive[i] && inbox(i, j)) tgt[j] = i;
      end
      for (int j = 0; j < BC; j++)
        if (tgt[j] >= 0 && !m_hit[tgt[j]]) begin m_hit[tgt[j]] = 1; m_bhit[j] = 1; end
      dead = m_hit;
      if (tick)
        for (int i = 0; i < EC; i++)
          if (m_alive[i] && !m_hit[i]) begin
            if (m_y[i] >= 10'd448) begin
              m_y[i] = 0; m_esc[i] = 1;
`ifdef ENEMY_ESCAPE_KILL_EN
              dead[i] = 1;
`endif
            end else m_y[i] = m_y[i] + 10'(step);
          end
      m_wc = (m_alive != 0) && ((m_alive & ~dead) == 0);
      m_alive = m_alive & ~dead;
      if (m_wc) m_act = 0;
    end else if (tick) begin
      m_ccnt++;
      if (m_ccnt == CT) begin
        m_ccnt = 0; m_wave = m_wave + 8'd1; m_act = 1; m_alive = '1;
        for (int i = 0; i < EC; i++) m_y[i] = 0;
      end
    end
  endtask

  function automatic logic [108:0] m_vec();
    logic [39:0] xs, ys;
    for (int i = 0; i < EC; i++) begin
      xs[i*10 +: 10] = 10'(200 + 50*i);
      ys[i*10 +: 10] = m_y[i];
    end
    return {xs, ys, m_alive, m_hit, m_bhit, m_esc, m_wc, m_wave};
  endfunction

  // Model step and scoreboard push, then pop and compare once the DUT has updated.
  always @(posedge clk25) begin
    if (!rst_n) m_reset();
    else begin m_step(); sb.push_back(m_vec()); end
  end
  always @(posedge clk25) begin
    #1;
    if (sb.size() != 0)
      chk("cycle", {fly_x_flat, fly_y_flat, fly_alive, fly_hit, bullet_hit,
                    enemy_escaped, wave_clear, wave_num}, sb.pop_front());
  end

  // ---------------- stimulus ----------------
  task automatic set_bullet(input int j, input int x, input int y);
    bx_flat[j*10 +: 10] = 10'(x);
    by_flat[j*10 +: 10] = 10'(y);
    bact[j] = 1'b1;
  endtask

  task automatic clr_bullets();
    bx_flat = '0; by_flat = '0; bact = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, fly_x_flat, {10'd350, 10'd300, 10'd250, 10'd200});
    chk({tag, "_y"}, fly_y_flat, 40'd0);
    chk({tag, "_alive"}, fly_alive, 4'b1111);
    chk({tag, "_wave"}, wave_num, 8'd0);
    chk({tag, "_pulses"}, {fly_hit, bullet_hit, enemy_escaped, wave_clear}, 17'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    clr_bullets();
    m_reset();
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;
    chk_reset_vals("rst");

    // Single hit: bullet 3 at (210,5) against enemy 0 at (200,0).
    set_bullet(3, 210, 5);
    @(negedge clk25);
    chk("hit_alive", fly_alive, 4'b1110);
    chk("hit_fly", fly_hit, 4'b0001);
    chk("hit_bullet", bullet_hit, 8'b00001000);
    clr_bullets();
    @(negedge clk25);
    chk("hit_width", {fly_hit, bullet_hit}, 12'd0);

    // Arbitration: bullets 1 and 5 both inside enemy 2.
    set_bullet(1, 310, int'(m_y[2]) + 5);
    set_bullet(5, 320, int'(m_y[2]) + 10);
    @(negedge clk25);
    chk("arb_bullet", bullet_hit, 8'b00000010);
    chk("arb_fly", fly_hit, 4'b0100);
    clr_bullets();
    @(negedge clk25);
    chk("arb_width", bullet_hit, 8'd0);

    // Wrap: survivors 1 and 3 descend until they reach the bottom.
    n = 0;
    while (enemy_escaped == 0 && n < 2000) begin @(negedge clk25); n++; end
    chk("esc_wait", n < 2000, 1'b1);
    chk("esc_vec", enemy_escaped, 4'b1010);
`ifdef ENEMY_ESCAPE_KILL_EN
    chk("esc_alive", fly_alive, 4'b0000);
    chk("esc_clear", wave_clear, 1'b1);
`else
    chk("esc_y", {fly_y_flat[39:30], fly_y_flat[19:10]}, 20'd0);
    chk("esc_alive", fly_alive, 4'b1010);
    // Kill the last two enemies in the same cycle.
    set_bullet(0, 260, int'(m_y[1]) + 5);
    set_bullet(2, 360, int'(m_y[3]) + 5);
    @(negedge clk25);
    chk("clr_fly", fly_hit, 4'b1010);
    chk("clr_bullet", bullet_hit, 8'b00000101);
    chk("clr_pulse", wave_clear, 1'b1);
    clr_bullets();
`endif

    // Wave advance after CLEAR_TICKS ticks.
    n = 0;
    while (wave_num != 8'd1 && n < 100) begin @(negedge clk25); n++; end
    chk("wave_wait", n < 100, 1'b1);
    chk("wave_num", wave_num, 8'd1);
    chk("wave_alive", fly_alive, 4'b1111);
    chk("wave_y", fly_y_flat, 40'd0);
    n = 0;
    while (fly_y_flat[9:0] == 0 && n < 20) begin @(negedge clk25); n++; end
    chk("step3", fly_y_flat[9:0], 10'd3);

    // Hitbox right edge: x = ex+32 misses and x = ex+31 hits.
    set_bullet(6, 232, int'(m_y[0]) + 5);
    @(negedge clk25);
    chk("edge_miss", {fly_hit, bullet_hit}, 12'd0);
    set_bullet(6, 231, int'(m_y[0]) + 31);
    @(negedge clk25);
    chk("edge_fly", fly_hit, 4'b0001);
    chk("edge_bullet", bullet_hit, 8'b01000000);
    clr_bullets();

    // Kill the rest at the inclusive corners of the box to enter CLEAR.
    set_bullet(0, 250, int'(m_y[1]));
    set_bullet(1, 331, int'(m_y[2]) + 31);
    set_bullet(2, 350, int'(m_y[3]));
    @(negedge clk25);
    chk("kill_fly", fly_hit, 4'b1110);
    chk("kill_bullet", bullet_hit, 8'b00000111);
    chk("kill_clear", wave_clear, 1'b1);
    clr_bullets();

    // Reset in the middle of CLEAR.
    repeat (8) @(negedge clk25);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    repeat (20) @(negedge clk25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
